// File: rtl/serial_cmd_tx_if.sv
// Command/serial-line bundle between a frame requester and serial_cmd_tx.
`timescale 1ns/1ps
interface serial_cmd_tx_if;
    logic       start;
    logic [7:0] cmd_data;
    logic       TX;
    logic       busy;
    logic       done;

    modport master (output start, cmd_data, input TX, busy, done);
    modport slave  (input start, cmd_data, output TX, busy, done);
endinterface

// File: rtl/serial_cmd_tx.sv
// Sends a 3-byte 8N1 frame (HEADER, cmd, HEADER^cmd) on TX; TX falls the cycle after start is accepted.
// start is only taken in IDLE; requests while busy are dropped, not queued.
`timescale 1ns/1ps
module serial_cmd_tx #(
    parameter int unsigned CLK_DIV = 5208,
    parameter logic [7:0]  HEADER  = 8'hA5
) (
    input logic            CLK,
    input logic            RESET,
    serial_cmd_tx_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  csum_q, csum_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        baud_wrap;
    logic [7:0]  next_byte;

    assign baud_wrap = (baud_q == BAUD_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            csum_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            csum_q  <= csum_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        data_d  = data_q;
        csum_d  = csum_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (bus.start) begin
                    data_d  = bus.cmd_data;
                    csum_d  = HEADER ^ bus.cmd_data;
                    idx_d   = 2'd0;
                    bit_d   = 3'd0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_wrap) begin
                    baud_d = '0;
                    // Next start bit follows the stop bit with no gap.
                    if (idx_q < 2'd2) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // TX is registered from the next state so the line moves with the state change.
    always_comb begin
        next_byte = HEADER;
        tx_d      = 1'b1;
        case (idx_d)
            2'd0:    next_byte = HEADER;
            2'd1:    next_byte = data_d;
            default: next_byte = csum_d;
        endcase
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = next_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.TX   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_serial_cmd_tx.sv
// Bench for serial_cmd_tx: fast-divider instance for frame behaviour, default-divider instance for baud timing.
`timescale 1ns/1ps
module tb_serial_cmd_tx;
    localparam int DIV  = 4;
    localparam int SDIV = 5208;

    logic CLK   = 1'b0;
    logic rst_f = 1'b1;
    logic rst_s = 1'b1;
    always #10 CLK = ~CLK;

    serial_cmd_tx_if if_f ();
    serial_cmd_tx_if if_s ();

    serial_cmd_tx #(.CLK_DIV(DIV), .HEADER(8'hA5)) u_fast (
        .CLK(CLK), .RESET(rst_f), .bus(if_f.slave)
    );
    serial_cmd_tx #(.CLK_DIV(SDIV), .HEADER(8'hA5)) u_slow (
        .CLK(CLK), .RESET(rst_s), .bus(if_s.slave)
    );

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int busy_cyc  = 0;
    logic [7:0] exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (if_f.done === 1'b1) done_cnt++;
        if (if_f.busy === 1'b1) busy_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] c);
        exp_q.push_back(8'hA5);
        exp_q.push_back(c);
        exp_q.push_back(8'hA5 ^ c);
    endtask

    task automatic send_f(input logic [7:0] c, output int t_acc);
        if_f.cmd_data = c;
        if_f.start    = 1'b1;
        push_frame(c);
        tick();
        t_acc       = cyc;
        if_f.start  = 1'b0;
        chk("accept_tx", if_f.TX, 1'b0);
        chk("accept_busy", if_f.busy, 1'b1);
    endtask

    task automatic wait_done(input string tag, output int t_done);
        int n;
        n = 0;
        while (if_f.done !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, if_f.done, 1'b1);
        chk({tag, "_busy_low"}, if_f.busy, 1'b0);
        t_done = cyc;
    endtask

    // Serial monitor: decodes each byte of the fast instance and pops the scoreboard.
    initial begin : mon
        logic [9:0] bits;
        logic       stable;
        logic       aborted;
        logic [7:0] exp_b;
        forever begin
            @(negedge CLK);
            if (rst_f === 1'b0 && if_f.TX === 1'b0) begin
                aborted = 1'b0;
                stable  = 1'b1;
                bits    = '0;
                for (int j = 0; j < 10 * DIV; j++) begin
                    if (j > 0) @(negedge CLK);
                    if (rst_f !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (j % DIV == 0) bits[j / DIV] = if_f.TX;
                    else if (if_f.TX !== bits[j / DIV]) stable = 1'b0;
                end
                if (!aborted) begin
                    chk("byte_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        exp_b = exp_q.pop_front();
                        chk("byte_value", bits[8:1], exp_b);
                        chk("byte_framing", {bits[9], bits[0], stable}, 3'b101);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int t0, td1, td2, d0, b0, n;
        real t_fall, bit_ns, target, width_ns;
        logic [7:0] rx;
        if_f.start = 1'b0; if_f.cmd_data = 8'h00;
        if_s.start = 1'b0; if_s.cmd_data = 8'h00;

        // reset
        repeat (3) begin
            tick();
            chk("rst_tx", if_f.TX, 1'b1);
            chk("rst_busy", if_f.busy, 1'b0);
            chk("rst_done", if_f.done, 1'b0);
        end
        rst_f = 1'b0;
        rst_s = 1'b0;
        tick();
        chk("post_rst_tx", if_f.TX, 1'b1);
        chk("post_rst_busy", if_f.busy, 1'b0);
        chk("post_rst_done", if_f.done, 1'b0);

        // single frame 0x3C
        d0 = done_cnt;
        b0 = busy_cyc;
        send_f(8'h3C, t0);
        wait_done("f1", td1);
        chk("f1_done_time", td1 - t0, 30 * DIV);
        chk("f1_done_tx", if_f.TX, 1'b1);
        tick();
        chk("f1_done_single", if_f.done, 1'b0);
        chk("f1_busy_cycles", busy_cyc - b0, 30 * DIV);
        chk("f1_done_count", done_cnt - d0, 1);
        chk("f1_sb_empty", exp_q.size(), 0);

        // start during a frame is dropped
        d0 = done_cnt;
        send_f(8'h81, t0);
        repeat (49) tick();
        if_f.cmd_data = 8'h55;
        if_f.start    = 1'b1;
        tick();
        if_f.start    = 1'b0;
        chk("ign_busy", if_f.busy, 1'b1);
        wait_done("ign", td1);
        chk("ign_done_time", td1 - t0, 30 * DIV);
        repeat (150) tick();
        chk("ign_done_count", done_cnt - d0, 1);
        chk("ign_busy_after", if_f.busy, 1'b0);
        chk("ign_sb_empty", exp_q.size(), 0);

        // back-to-back with start held high
        d0 = done_cnt;
        if_f.cmd_data = 8'h00;
        if_f.start    = 1'b1;
        push_frame(8'h00);
        tick();
        t0 = cyc;
        wait_done("b2b_1", td1);
        chk("b2b_1_time", td1 - t0, 30 * DIV);
        if_f.cmd_data = 8'hFF;
        push_frame(8'hFF);
        tick();
        if_f.start = 1'b0;
        chk("b2b_no_gap_tx", if_f.TX, 1'b0);
        chk("b2b_no_gap_busy", if_f.busy, 1'b1);
        wait_done("b2b_2", td2);
        chk("b2b_done_spacing", td2 - td1, 30 * DIV + 1);
        repeat (150) tick();
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("b2b_sb_empty", exp_q.size(), 0);

        // reset during byte 1, data bit 3
        d0 = done_cnt;
        send_f(8'h42, t0);
        repeat (57) tick();
        rst_f = 1'b1;
        exp_q.delete();
        tick();
        chk("mid_rst_tx", if_f.TX, 1'b1);
        chk("mid_rst_busy", if_f.busy, 1'b0);
        chk("mid_rst_done", if_f.done, 1'b0);
        rst_f = 1'b0;
        repeat (150) tick();
        chk("mid_rst_no_done", done_cnt - d0, 0);
        send_f(8'hC3, t0);
        wait_done("after_rst", td1);
        chk("after_rst_time", td1 - t0, 30 * DIV);
        tick();
        chk("after_rst_sb_empty", exp_q.size(), 0);

        // default divider: bit width and 9600-baud decode of the header byte
        if_s.cmd_data = 8'h80;
        if_s.start    = 1'b1;
        @(posedge CLK);
        t_fall = $realtime;
        #1;
        if_s.start = 1'b0;
        chk("slow_accept_tx", if_s.TX, 1'b0);
        n = 0;
        while (if_s.TX === 1'b0 && n < 6000) begin
            tick();
            n++;
        end
        chk("slow_bit_cycles", n, SDIV);
        width_ns = $realtime - 1.0 - t_fall;
        chk("slow_bit_ns", $rtoi(width_ns + 0.5), 104160);
        bit_ns = 1.0e9 / 9600.0;
        rx = '0;
        for (int k = 1; k <= 9; k++) begin
            target = t_fall + (k + 0.5) * bit_ns;
            #(target - $realtime);
            if (k <= 8) rx[k - 1] = if_s.TX;
            else chk("slow_stop_bit", if_s.TX, 1'b1);
        end
        chk("slow_header", rx, 8'hA5);
        rst_s = 1'b1;
        tick();
        chk("slow_rst_tx", if_s.TX, 1'b1);
        rst_s = 1'b0;

        chk("final_sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
